// File: rtl/axi_dma_rd_desc_mux_if.sv
// axi_dma_rd_desc_mux_if: N-lane read-descriptor stream with its returning completion status.
//   master: drives descriptor fields + valid, receives ready and the status strobe.
//   slave : receives descriptor fields + valid, drives ready and the status strobe.
//   Lane i of every vector lives at slice i (addr[i*AW +: AW], status_error[i*4 +: 4], ...).
interface axi_dma_rd_desc_mux_if #(
  parameter int N  = 1,
  parameter int AW = 16,
  parameter int LW = 20,
  parameter int TW = 8,
  parameter int IW = 8,
  parameter int DW = 8,
  parameter int UW = 1
);
  logic [N*AW-1:0] addr;
  logic [N*LW-1:0] len;
  logic [N*TW-1:0] tag;
  logic [N*IW-1:0] id;
  logic [N*DW-1:0] dest;
  logic [N*UW-1:0] user;
  logic [N-1:0]    valid;
  logic [N-1:0]    ready;
  logic [N*TW-1:0] status_tag;
  logic [N*4-1:0]  status_error;
  logic [N-1:0]    status_valid;
  modport master (
    output addr, len, tag, id, dest, user, valid,
    input  ready, status_tag, status_error, status_valid
  );
  modport slave (
    input  addr, len, tag, id, dest, user, valid,
    output ready, status_tag, status_error, status_valid
  );
endinterface

// File: rtl/axi_dma_rd_desc_mux.sv
// axi_dma_rd_desc_mux: round-robin mux of PORTS descriptor sources onto one DMA read engine,
//   with the engine's completion status routed back to the source named in the tag's top bits.
//   clk   : clock, rising edge
//   rst_n : synchronous reset, active low
//   src   : PORTS-lane slave side (descriptors in, per-port ready, per-port status out)
//   eng   : 1-lane master side (descriptor out with {port, tag}, engine ready, status in)
module axi_dma_rd_desc_mux #(
  parameter int PORTS           = 4,
  parameter int AXI_ADDR_WIDTH  = 16,
  parameter int LEN_WIDTH       = 20,
  parameter int S_TAG_WIDTH     = 8,
  parameter int AXIS_ID_WIDTH   = 8,
  parameter int AXIS_DEST_WIDTH = 8,
  parameter int AXIS_USER_WIDTH = 1
) (
  input logic clk,
  input logic rst_n,
  axi_dma_rd_desc_mux_if.slave  src,
  axi_dma_rd_desc_mux_if.master eng
);
  localparam int PW = $clog2(PORTS);
  localparam int M_TAG_WIDTH = S_TAG_WIDTH + PW;
  localparam int W = AXI_ADDR_WIDTH + LEN_WIDTH + M_TAG_WIDTH + AXIS_ID_WIDTH + AXIS_DEST_WIDTH + AXIS_USER_WIDTH;
  logic [PW-1:0] ptr, win, st_port;
  logic found, accept, out_valid, tmp_valid;
  logic [W-1:0] in_d, out_d, tmp_d;
  // Scan from the highest offset down so the lowest offset from ptr that is valid wins.
  always_comb begin
    win = ptr;
    found = 1'b0;
    for (int k = PORTS - 1; k >= 0; k--)
      if (src.valid[(int'(ptr) + k) % PORTS]) begin
        found = 1'b1;
        win = PW'((int'(ptr) + k) % PORTS);
      end
  end
  // Acceptance depends only on the skid slot being free, never on eng.ready.
  assign accept = rst_n && found && !tmp_valid;
  assign src.ready = {{(PORTS-1){1'b0}}, accept} << win;
  assign in_d = {src.addr[win*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH],
                 src.len[win*LEN_WIDTH +: LEN_WIDTH],
                 win,
                 src.tag[win*S_TAG_WIDTH +: S_TAG_WIDTH],
                 src.id[win*AXIS_ID_WIDTH +: AXIS_ID_WIDTH],
                 src.dest[win*AXIS_DEST_WIDTH +: AXIS_DEST_WIDTH],
                 src.user[win*AXIS_USER_WIDTH +: AXIS_USER_WIDTH]};
  assign {eng.addr, eng.len, eng.tag, eng.id, eng.dest, eng.user} = out_d;
  assign eng.valid = out_valid;
  // Output register plus one temp slot: the temp slot catches the descriptor accepted in
  // the cycle the engine stalls, and refills the output register first when it drains.
  always_ff @(posedge clk)
    if (!rst_n) begin
      ptr <= '0;
      out_valid <= 1'b0;
      tmp_valid <= 1'b0;
      out_d <= '0;
      tmp_d <= '0;
    end else begin
      if (accept) ptr <= PW'((int'(win) + 1) % PORTS);
      if (eng.ready[0] || !out_valid) begin
        out_valid <= tmp_valid || accept;
        out_d <= tmp_valid ? tmp_d : accept ? in_d : out_d;
        tmp_valid <= 1'b0;
      end else if (accept) begin
        tmp_valid <= 1'b1;
        tmp_d <= in_d;
      end
    end
  // Port indices >= PORTS never match, so such statuses are dropped.
  assign st_port = eng.status_tag[M_TAG_WIDTH-1 -: PW];
  always_ff @(posedge clk)
    if (!rst_n) begin
      src.status_valid <= '0;
      src.status_tag <= '0;
      src.status_error <= '0;
    end else
      for (int p = 0; p < PORTS; p++) begin
        src.status_valid[p] <= eng.status_valid[0] && st_port == PW'(p);
        if (eng.status_valid[0] && st_port == PW'(p)) begin
          src.status_tag[p*S_TAG_WIDTH +: S_TAG_WIDTH] <= eng.status_tag[S_TAG_WIDTH-1:0];
          src.status_error[p*4 +: 4] <= eng.status_error;
        end
      end
endmodule

// File: tb/tb_axi_dma_rd_desc_mux.sv
// tb_axi_dma_rd_desc_mux: directed checks of reset, tagging, round-robin, skid backpressure and status routing, plus a randomized order scoreboard.
module tb_axi_dma_rd_desc_mux;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_tests = 0;
  int n_fail = 0;
  logic [3:0] acc;
  logic [25:0] sb[$];
  int bp_acc;
  always #5 clk = ~clk;
  axi_dma_rd_desc_mux_if #(.N(4), .TW(8)) src();
  axi_dma_rd_desc_mux_if #(.N(1), .TW(10)) eng();
  axi_dma_rd_desc_mux dut (.clk(clk), .rst_n(rst_n), .src(src), .eng(eng));
  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    rst_n = 1'b0;
    src.valid = '0;
    eng.status_valid = '0;
    tick;
    tick;
    rst_n = 1'b1;
    tick;
  endtask
  // Sample handshakes mid-cycle: push granted descriptors, pop and compare delivered ones.
  task automatic sample;
    @(negedge clk);
    acc = src.ready & src.valid;
    check("rnd_onehot", 64'($countones(src.ready) <= 1), 64'd1);
    check("rnd_rdy_no_valid", 64'(src.ready & ~src.valid), 64'd0);
    for (int p = 0; p < 4; p++)
      if (acc[p]) sb.push_back({src.addr[p*16 +: 16], 2'(p), src.tag[p*8 +: 8]});
    if (eng.valid[0] && eng.ready[0]) begin
      if (sb.size() == 0) check("rnd_extra", 64'd1, 64'd0);
      else check("rnd_data", 64'({eng.addr, eng.tag}), 64'(sb.pop_front()));
    end
    @(posedge clk);
    #1;
  endtask
  initial begin
    src.addr = '0; src.len = '0; src.tag = '0; src.id = '0; src.dest = '0; src.user = '0;
    src.valid = '0;
    eng.ready = '0; eng.status_tag = '0; eng.status_error = '0; eng.status_valid = '0;
    src.valid = '1;
    eng.status_valid = 1'b1;
    eng.status_tag = 10'h155;
    repeat (3) tick;
    check("rst_ready", 64'(src.ready), 64'd0);
    check("rst_mvalid", 64'(eng.valid), 64'd0);
    check("rst_svalid", 64'(src.status_valid), 64'd0);
    check("rst_maddr", 64'(eng.addr), 64'd0);
    src.valid = '0;
    eng.status_valid = '0;
    rst_n = 1'b1;
    tick;
    src.addr[2*16 +: 16] = 16'h1000;
    src.len[2*20 +: 20] = 20'd64;
    src.tag[2*8 +: 8] = 8'h5A;
    src.valid = 4'b0100;
    #1;
    check("sp_ready", 64'(src.ready), 64'b0100);
    tick;
    src.valid = '0;
    check("sp_valid", 64'(eng.valid), 64'd1);
    check("sp_addr", 64'(eng.addr), 64'h1000);
    check("sp_len", 64'(eng.len), 64'd64);
    check("sp_tag", 64'(eng.tag), 64'h25A);
    eng.ready = 1'b1;
    tick;
    check("sp_drain", 64'(eng.valid), 64'd0);
    do_reset;
    for (int i = 0; i < 4; i++) src.tag[i*8 +: 8] = 8'(8'h10 + i);
    src.valid = '1;
    #1;
    check("fair_rdy0", 64'(src.ready), 64'b0001);
    for (int c = 0; c < 8; c++) begin
      tick;
      check("fair_valid", 64'(eng.valid), 64'd1);
      check("fair_tag", 64'(eng.tag), 64'(((c % 4) << 8) | (16'h10 + c % 4)));
      check("fair_rdy", 64'(src.ready), 64'(1 << ((c + 1) % 4)));
    end
    src.valid = '0;
    tick;
    check("fair_end", 64'(eng.valid), 64'd0);
    do_reset;
    eng.ready = 1'b0;
    src.tag[0 +: 8] = 8'hA0;
    src.tag[8 +: 8] = 8'hB1;
    src.valid = 4'b0011;
    #1;
    bp_acc = 0;
    for (int c = 0; c < 10; c++) begin
      acc = src.ready;
      if (acc != 0) bp_acc++;
      tick;
      for (int p = 0; p < 2; p++) if (acc[p]) src.tag[p*8 +: 8] = src.tag[p*8 +: 8] + 8'd1;
      check("bp_valid", 64'(eng.valid), 64'd1);
      check("bp_stable", 64'(eng.tag), 64'h0A0);
    end
    check("bp_accepts", 64'(bp_acc), 64'd2);
    src.valid = '0;
    eng.ready = 1'b1;
    tick;
    check("bp_rel_valid", 64'(eng.valid), 64'd1);
    check("bp_rel_tag", 64'(eng.tag), 64'h1B1);
    tick;
    check("bp_rel_end", 64'(eng.valid), 64'd0);
    eng.status_valid = 1'b1;
    eng.status_tag = 10'h3C7;
    eng.status_error = 4'd0;
    tick;
    eng.status_tag = 10'h011;
    eng.status_error = 4'd2;
    check("st1_valid", 64'(src.status_valid), 64'b1000);
    check("st1_tag", 64'(src.status_tag[3*8 +: 8]), 64'hC7);
    check("st1_err", 64'(src.status_error[3*4 +: 4]), 64'd0);
    tick;
    eng.status_valid = 1'b0;
    check("st2_valid", 64'(src.status_valid), 64'b0001);
    check("st2_tag", 64'(src.status_tag[0 +: 8]), 64'h11);
    check("st2_err", 64'(src.status_error[0 +: 4]), 64'd2);
    tick;
    check("st3_valid", 64'(src.status_valid), 64'd0);
    do_reset;
    acc = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int p = 0; p < 4; p++)
        if (!(src.valid[p] && !acc[p])) begin
          src.valid[p] = 1'($urandom_range(0, 1));
          src.addr[p*16 +: 16] = 16'($urandom);
          src.len[p*20 +: 20] = 20'($urandom);
          src.tag[p*8 +: 8] = 8'($urandom);
        end
      eng.ready = 1'($urandom_range(0, 3) != 0);
      #1;
      sample;
    end
    src.valid = '0;
    eng.ready = 1'b1;
    #1;
    for (int c = 0; c < 5; c++) sample;
    check("rnd_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
